// File: rtl/memory_stage_if.sv
// Execute-to-MEM bundle plus the MEM stage's write-back, branch and fault outputs.
// The master is the execute side (or a bench); memory_stage takes the slave modport.
interface memory_stage_if;
  logic        stall;
  logic        flush;
  logic [6:0]  branch_pc;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] data2_out;
  logic [4:0]  dst;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        reg_write;
  logic        mem_to_reg;

  logic        pc_src;
  logic [6:0]  branch_target;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_dst;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        mem_fault;

  modport master (
    output stall, flush, branch_pc, zero, alu_result, data2_out, dst,
           mem_read, mem_write, branch, reg_write, mem_to_reg,
    input  pc_src, branch_target, wb_read_data, wb_alu_result, wb_dst,
           wb_reg_write, wb_mem_to_reg, mem_fault
  );

  modport slave (
    input  stall, flush, branch_pc, zero, alu_result, data2_out, dst,
           mem_read, mem_write, branch, reg_write, mem_to_reg,
    output pc_src, branch_target, wb_read_data, wb_alu_result, wb_dst,
           wb_reg_write, wb_mem_to_reg, mem_fault
  );
endinterface

// File: rtl/memory_stage.sv
// MEM stage: EX/MEM reg, word-addressed sync data memory, branch decision, MEM/WB reg; wb_* valid 2 edges
// after execute; stall freezes both registers and blocks stores. Optional macro UNALIGNED_CHECK_EN.
module memory_stage #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic         clk,
  input  logic         rst,
  memory_stage_if.slave bus
);

  typedef struct packed {
    logic [6:0]  branch_pc;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] data2;
    logic [4:0]  dst;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        reg_write;
    logic        mem_to_reg;
  } exm_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  dst;
    logic        reg_write;
    logic        mem_to_reg;
  } mwb_t;

  exm_t              r_exm;
  mwb_t              r_mwb;
  exm_t              w_exm_in;
  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] w_idx;
  logic              w_misaligned;
  logic              w_store_en;
  logic              w_unused;

  // A flushed entry keeps its data but loses every control bit.
  assign w_exm_in = {bus.branch_pc, bus.zero, bus.alu_result, bus.data2_out, bus.dst,
                     bus.mem_read   & ~bus.flush,
                     bus.mem_write  & ~bus.flush,
                     bus.branch     & ~bus.flush,
                     bus.reg_write  & ~bus.flush,
                     bus.mem_to_reg & ~bus.flush};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exm <= '0;
    end else if (bus.flush || !bus.stall) begin
      r_exm <= w_exm_in;
    end
  end

  assign w_idx    = r_exm.alu_result[ADDR_W+1:2];
  assign w_unused = ^{r_exm.alu_result[31:ADDR_W+2], r_exm.alu_result[1:0]};

`ifdef UNALIGNED_CHECK_EN
  logic r_fault;

  assign w_misaligned = (r_exm.mem_read | r_exm.mem_write) & (r_exm.alu_result[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_misaligned && !bus.stall) begin
      r_fault <= 1'b1;
    end
  end

  assign bus.mem_fault = r_fault;
`else
  assign w_misaligned  = 1'b0;
  assign bus.mem_fault = 1'b0;
`endif

  assign w_store_en = r_exm.mem_write & ~bus.stall & ~rst & ~w_misaligned;

  always_ff @(posedge clk) begin
    if (w_store_en) begin
      r_mem[w_idx] <= r_exm.data2;
    end
  end

  // Read samples the pre-store word, giving read-before-write within one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mwb <= '0;
    end else if (!bus.stall) begin
      r_mwb.read_data  <= (r_exm.mem_read && !w_misaligned) ? r_mem[w_idx] : 32'h0;
      r_mwb.alu_result <= r_exm.alu_result;
      r_mwb.dst        <= r_exm.dst;
      r_mwb.reg_write  <= r_exm.reg_write & ~w_misaligned;
      r_mwb.mem_to_reg <= r_exm.mem_to_reg;
    end
  end

  assign bus.pc_src        = r_exm.branch & r_exm.zero;
  assign bus.branch_target = r_exm.branch_pc;
  assign bus.wb_read_data  = r_mwb.read_data;
  assign bus.wb_alu_result = r_mwb.alu_result;
  assign bus.wb_dst        = r_mwb.dst;
  assign bus.wb_reg_write  = r_mwb.reg_write;
  assign bus.wb_mem_to_reg = r_mwb.mem_to_reg;

endmodule
